// File: rtl/image_feed_ctrl.sv
// Credit-based pixel feeder for a KxK window generator: streams one frame of
// IMG_H lines, throttled by free downstream line buffers, and tags windows.
module image_feed_ctrl #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int K     = 5,
  parameter int NBUF  = 6
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic [7:0] o_pixel_data,
  output logic       o_pixel_data_valid,
  input  logic       i_intr,
  input  logic       i_win_valid,
  output logic [5:0] o_win_col,
  output logic [4:0] o_win_row,
  output logic       o_win_keep,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LW = $clog2(IMG_H + 1);
  localparam int BW = $clog2(NBUF + 1);

  localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);
  localparam logic [LW-1:0] LINE_LAST   = LW'(IMG_H - 1);
  localparam logic [LW-1:0] ROWS_TARGET = LW'(IMG_H - K + 1);
  localparam logic [BW-1:0] CRED_MAX    = BW'(NBUF);
  localparam logic [5:0]    WCOL_LAST   = 6'(IMG_W - 1);
  localparam logic [5:0]    KEEP_MAX    = 6'(IMG_W - K);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] pix_col;
  logic [LW-1:0] lines_in;
  logic [LW-1:0] rows_out;
  logic [LW-1:0] rows_inc;
  logic [BW-1:0] credits;
  logic          frame_start;
  logic          xfer;
  logic          line_done;
  logic          intr_act;
  logic          overflow;

  always_comb begin
    frame_start = (state == IDLE) && i_start;
    o_s_ready   = (state == STREAM) && (credits != '0);
    xfer        = i_s_valid && o_s_ready;
    line_done   = xfer && (pix_col == COL_LAST);
    intr_act    = i_intr && ((state == STREAM) || (state == DRAIN));
    overflow    = intr_act && !line_done && (credits == CRED_MAX);
    rows_inc    = rows_out + LW'(1);
    // Keep is forced low while reset is held, since i_win_valid is external.
    o_win_keep  = i_win_valid && !i_rst && (o_win_col <= KEEP_MAX);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start) state_next = STREAM;
      end
      STREAM: begin
        o_busy = 1'b1;
        if (line_done && (lines_in == LINE_LAST)) state_next = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if ((intr_act ? rows_inc : rows_out) >= ROWS_TARGET) state_next = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pix_col            <= '0;
      lines_in           <= '0;
      rows_out           <= '0;
      credits            <= CRED_MAX;
      o_err              <= 1'b0;
      o_pixel_data       <= '0;
      o_pixel_data_valid <= 1'b0;
      o_win_col          <= '0;
      o_win_row          <= '0;
    end else begin
      o_pixel_data_valid <= xfer;
      if (xfer) o_pixel_data <= i_s_data;
      if (overflow) o_err <= 1'b1;

      if (frame_start) begin
        pix_col   <= '0;
        lines_in  <= '0;
        rows_out  <= '0;
        credits   <= CRED_MAX;
        o_win_col <= '0;
        o_win_row <= '0;
      end else begin
        if (xfer) begin
          pix_col <= line_done ? '0 : pix_col + CW'(1);
          if (line_done) lines_in <= lines_in + LW'(1);
        end
        if (intr_act) rows_out <= rows_inc;
        // A freed line and a consumed line in the same cycle cancel out.
        case ({intr_act, line_done})
          2'b10:   if (credits != CRED_MAX) credits <= credits + BW'(1);
          2'b01:   credits <= credits - BW'(1);
          default: credits <= credits;
        endcase
        if (i_win_valid) begin
          if (o_win_col == WCOL_LAST) begin
            o_win_col <= '0;
            o_win_row <= o_win_row + 5'd1;
          end else begin
            o_win_col <= o_win_col + 6'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_image_feed_ctrl.sv
// Directed self-checking bench for image_feed_ctrl with default parameters
// (32x32 image, 5x5 window, 6 line credits).
module tb_image_feed_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_s_data = '0;
  logic       i_s_valid = 1'b0;
  logic       o_s_ready;
  logic [7:0] o_pixel_data;
  logic       o_pixel_data_valid;
  logic       i_intr = 1'b0;
  logic       i_win_valid = 1'b0;
  logic [5:0] o_win_col;
  logic [4:0] o_win_row;
  logic       o_win_keep;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int errors = 0;
  int checks = 0;
  int rx_cnt;
  int rx_bad;
  int intr_cnt;
  int done_at_last_intr;

  image_feed_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .i_intr(i_intr), .i_win_valid(i_win_valid),
    .o_win_col(o_win_col), .o_win_row(o_win_row), .o_win_keep(o_win_keep),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    cycle();
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
  endtask

  task automatic pulse_intr();
    i_intr = 1'b1;
    cycle();
    i_intr = 1'b0;
  endtask

  // Stream up to max pixels with continuous valid; stop early once ready has
  // been low for 4 cycles. intr_at asserts i_intr alongside that transfer.
  task automatic feed(input int max, input int intr_at, output int n);
    int idle = 0;
    n = 0;
    for (int c = 0; c < max + 40; c++) begin
      if (n == max) break;
      i_s_valid = 1'b1;
      i_s_data  = 8'(n);
      i_intr    = 1'b0;
      if (!o_s_ready) begin
        idle++;
        if (idle >= 4) break;
      end else begin
        idle   = 0;
        i_intr = (n == intr_at);
        n++;
      end
      cycle();
    end
    i_s_valid = 1'b0;
    i_intr    = 1'b0;
  endtask

  // Full frame with a simple window-generator model: each output row needs
  // K lines delivered, then emits 32 windows followed by one intr.
  task automatic run_frame(input string tag);
    int extra = 0;
    rx_cnt = 0;
    rx_bad = 0;
    intr_cnt = 0;
    done_at_last_intr = 0;
    start_frame();
    check({tag, "_busy_start"}, o_busy, 1);
    fork
      begin : feeder
        int tx = 0;
        int guard = 0;
        while (rx_cnt < 1024 && guard < 6000) begin
          if (o_pixel_data_valid) begin
            if (o_pixel_data != 8'(rx_cnt)) rx_bad++;
            rx_cnt++;
          end
          if (tx < 1024) begin
            i_s_valid = 1'b1;
            i_s_data  = 8'(tx);
            if (o_s_ready) tx++;
          end else begin
            i_s_valid = 1'b0;
          end
          cycle();
          guard++;
        end
        i_s_valid = 1'b0;
      end
      begin : win_model
        for (int r = 0; r < 28; r++) begin
          int g = 0;
          while (rx_cnt < (r + 5) * 32 && g < 6000) begin
            cycle();
            g++;
          end
          repeat (32) begin
            i_win_valid = 1'b1;
            cycle();
          end
          i_win_valid = 1'b0;
          i_intr = 1'b1;
          cycle();
          i_intr = 1'b0;
          intr_cnt++;
          if (r == 27) done_at_last_intr = int'(o_done);
        end
      end
    join
    check({tag, "_rx_count"}, rx_cnt, 1024);
    check({tag, "_data_order_bad"}, rx_bad, 0);
    check({tag, "_intr_count"}, intr_cnt, 28);
    check({tag, "_done_after_last_intr"}, done_at_last_intr, 1);
    check({tag, "_win_row_end"}, int'(o_win_row), 28);
    check({tag, "_win_col_end"}, int'(o_win_col), 0);
    check({tag, "_err"}, o_err, 0);
    cycle();
    check({tag, "_done_one_cycle"}, o_done, 0);
    check({tag, "_busy_end"}, o_busy, 0);
    repeat (3) begin
      if (o_pixel_data_valid) extra++;
      cycle();
    end
    check({tag, "_extra_pixels"}, extra, 0);
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    #1;
    i_rst = 1'b0;
    cycle();

    // Reset state
    check("rst_s_ready", o_s_ready, 0);
    check("rst_pix_valid", o_pixel_data_valid, 0);
    check("rst_pix_data", int'(o_pixel_data), 0);
    check("rst_win_col", int'(o_win_col), 0);
    check("rst_win_row", int'(o_win_row), 0);
    check("rst_win_keep", o_win_keep, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);

    // intr in IDLE is ignored
    pulse_intr();
    check("idle_intr_err", o_err, 0);
    check("idle_ready", o_s_ready, 0);

    // Full frame
    run_frame("frame1");

    // Credit stall: 6 lines then stop; one intr frees exactly one line
    start_frame();
    check("stall_ready_start", o_s_ready, 1);
    feed(1000, -1, n);
    check("stall_first_burst", n, 192);
    check("stall_ready_low", o_s_ready, 0);
    i_start = 1'b1;
    cycle();
    i_start = 1'b0;
    check("start_ignored_in_stream", o_s_ready, 0);
    pulse_intr();
    feed(1000, -1, n);
    check("stall_after_one_intr", n, 32);

    // Simultaneous intr and line completion at credits=1
    pulse_intr();
    check("simul_credits_before", int'(dut.credits), 1);
    feed(32, 31, n);
    check("simul_xfers", n, 32);
    check("simul_ready", o_s_ready, 1);
    check("simul_credits", int'(dut.credits), 1);
    check("simul_err", o_err, 0);
    feed(1000, -1, n);
    check("simul_next_line", n, 32);

    // Overflow at full credits
    do_reset();
    start_frame();
    pulse_intr();
    check("ovf_err", o_err, 1);
    check("ovf_credits", int'(dut.credits), 6);
    cycle();
    cycle();
    check("ovf_err_held", o_err, 1);
    check("ovf_ready", o_s_ready, 1);

    // Window tagging over two rows
    do_reset();
    check("reset_clears_err", o_err, 0);
    start_frame();
    for (int i = 0; i < 64; i++) begin
      i_win_valid = 1'b1;
      #1;
      check($sformatf("win_keep_%0d", i), o_win_keep, ((i % 32) <= 27) ? 1 : 0);
      cycle();
    end
    i_win_valid = 1'b0;
    #1;
    check("win_keep_idle", o_win_keep, 0);
    check("win_row_after_64", int'(o_win_row), 2);
    check("win_col_after_64", int'(o_win_col), 0);

    // Reset mid-frame
    do_reset();
    start_frame();
    feed(100, -1, n);
    check("midrst_xfers", n, 100);
    i_win_valid = 1'b1;
    i_s_valid   = 1'b1;
    i_rst       = 1'b1;
    #1;
    check("midrst_s_ready", o_s_ready, 0);
    check("midrst_pix_valid", o_pixel_data_valid, 0);
    check("midrst_pix_data", int'(o_pixel_data), 0);
    check("midrst_win_col", int'(o_win_col), 0);
    check("midrst_win_row", int'(o_win_row), 0);
    check("midrst_win_keep", o_win_keep, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_err", o_err, 0);
    cycle();
    i_rst       = 1'b0;
    i_win_valid = 1'b0;
    cycle();
    cycle();
    check("postrst_no_xfer", o_pixel_data_valid, 0);
    check("postrst_ready", o_s_ready, 0);
    i_s_valid = 1'b0;
    run_frame("frame2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
